// File: rtl/mem_io_bridge.sv
// Memory/IO bridge behind the CPU byte bus: RAM pass-through, UART TX FIFO and RX pop,
// free-running cycle counter with coherent snapshot, and the program-stop drain handshake.
module mem_io_bridge #(
    parameter int TX_DEPTH_LOG = 4,
    parameter int FULL_MARGIN  = 2,
    parameter int RAM_AW       = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       cpu_a,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_din,
    output logic              io_buffer_full,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic              program_finish,
    output logic              tx_overflow
);
    localparam int DEPTH = 1 << TX_DEPTH_LOG;
    localparam int PW    = TX_DEPTH_LOG + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic          io_full_q, io_full_d;
    logic          overflow_q, overflow_d;
    logic          finish_req_q, finish_req_d;

    logic          is_io, port_sel, cnt0_sel, cpu_rd;
    logic          push_req, push_ok, pop, fifo_full;
    logic [PW-1:0] count, count_nxt;
    logic          unused_addr;

    assign unused_addr = ^cpu_a[31:18];
    assign is_io       = (cpu_a[17:16] == 2'b11);
    assign port_sel    = is_io & (cpu_a[2:0] == 3'b000);
    assign cnt0_sel    = is_io & (cpu_a[2:0] == 3'b100);
    assign cpu_rd      = rdy_in & ~cpu_wr & ~rst_in;

    assign ram_a     = cpu_a[RAM_AW-1:0];
    assign ram_wdata = cpu_dout;
    assign ram_we    = cpu_wr & ~is_io & rdy_in & ~rst_in;
    assign rx_pop    = cpu_rd & port_sel & rx_valid;

    assign count     = wptr_q - rptr_q;
    assign fifo_full = (count == PW'(DEPTH));
    assign tx_valid  = (count != '0);
    assign tx_data   = mem_q[rptr_q[TX_DEPTH_LOG-1:0]];
    assign pop       = tx_valid & tx_ready;
    assign push_req  = cpu_wr & rdy_in & port_sel & (cpu_dout != 8'h00);
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok   = push_req & (~fifo_full | pop);

    assign io_buffer_full = io_full_q;
    assign tx_overflow    = overflow_q;
    assign program_finish = (state_q == ST_DONE);

    always_comb begin
        cpu_din = 8'h00;
        if (!sel_q[3]) begin
            cpu_din = ram_rdata;
        end else if (sel_q[2:0] == 3'b000) begin
            cpu_din = rx_byte_q;
        end else if (sel_q[2]) begin
            cpu_din = snap_q[{sel_q[1:0], 3'b000} +: 8];
        end
    end

    always_comb begin
        sel_d        = sel_q;
        snap_d       = snap_q;
        rx_byte_d    = rx_byte_q;
        cnt_d        = cnt_q + 32'd1;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        mem_d        = mem_q;
        overflow_d   = overflow_q;
        finish_req_d = finish_req_q;
        if (rdy_in) begin
            sel_d = {is_io, cpu_a[2:0]};
        end
        if (cpu_rd && cnt0_sel) begin
            snap_d = cnt_q;
        end
        if (cpu_rd && port_sel) begin
            rx_byte_d = rx_valid ? rx_data : 8'h00;
        end
        if (push_ok) begin
            mem_d[wptr_q[TX_DEPTH_LOG-1:0]] = cpu_dout;
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (cpu_wr && rdy_in && cnt0_sel) begin
            finish_req_d = 1'b1;
        end
    end

    // Registered so the CPU sees it a cycle late; the margin covers that lag.
    assign count_nxt = wptr_d - rptr_d;
    assign io_full_d = (count_nxt >= PW'(DEPTH - FULL_MARGIN));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (finish_req_q) state_d = ST_DRAIN;
            ST_DRAIN: if (count == '0 && !push_ok) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_RUN;
            sel_q        <= '0;
            cnt_q        <= '0;
            snap_q       <= '0;
            rx_byte_q    <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            mem_q        <= '{default: '0};
            io_full_q    <= 1'b0;
            overflow_q   <= 1'b0;
            finish_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            rx_byte_q    <= rx_byte_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            mem_q        <= mem_d;
            io_full_q    <= io_full_d;
            overflow_q   <= overflow_d;
            finish_req_q <= finish_req_d;
        end
    end
endmodule
